// File: rtl/gmii_rx_checker_if.sv
// GMII receive bus plus forwarded-byte stream and per-frame status of the RX frame checker.
// The master side is the PHY/converter and the downstream consumer; the slave side is the checker.
interface gmii_rx_checker_if #(
  parameter int unsigned CNT_W = 16
) ();
  logic             gmii_rx_dv;
  logic [7:0]       gmii_rxd;
  logic             out_dv;
  logic [7:0]       out_data;
  logic             out_sof;
  logic             frame_done;
  logic             frame_ok;
  logic             crc_err;
  logic             addr_miss;
  logic             len_err;
  logic             pre_err;
  logic [CNT_W-1:0] good_cnt;
  logic [CNT_W-1:0] bad_cnt;

  modport master (
    output gmii_rx_dv, gmii_rxd,
    input  out_dv, out_data, out_sof, frame_done, frame_ok,
           crc_err, addr_miss, len_err, pre_err, good_cnt, bad_cnt
  );

  modport slave (
    input  gmii_rx_dv, gmii_rxd,
    output out_dv, out_data, out_sof, frame_done, frame_ok,
           crc_err, addr_miss, len_err, pre_err, good_cnt, bad_cnt
  );
endinterface

// File: rtl/gmii_rx_checker.sv
// Receive-side GMII frame checker: strips preamble/SFD, forwards DA..FCS with one cycle of
// latency and reports FCS, destination-MAC, length and preamble status per frame.
module gmii_rx_checker #(
  parameter logic [47:0] BOARD_MAC = 48'h00_11_22_33_44_55,
  parameter int unsigned MIN_LEN   = 64,
  parameter int unsigned MAX_LEN   = 1518,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             gmii_rx_clk,
  input  logic             rst_n,
  gmii_rx_checker_if.slave rx
);

  localparam int unsigned BYTE_CNT_W = 11;
  localparam int unsigned PRE_CNT_W  = 3;
  localparam logic [31:0] CRC_INIT   = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC_RESID  = 32'hDEBB_20E3;
  localparam logic [31:0] CRC_POLY_R = 32'hEDB8_8320;

  typedef enum logic [2:0] {
    S_WAIT_IDLE = 3'd0,
    S_IDLE      = 3'd1,
    S_PRE       = 3'd2,
    S_DATA      = 3'd3,
    S_DROP      = 3'd4
  } state_t;

  state_t                r_state;
  logic [PRE_CNT_W-1:0]  r_pre_cnt;
  logic [BYTE_CNT_W-1:0] r_byte_cnt;
  logic [31:0]           r_crc;
  logic                  r_da_bcast;
  logic                  r_da_board;
  logic                  r_out_dv;
  logic [7:0]            r_out_data;
  logic                  r_out_sof;
  logic                  r_frame_done;
  logic                  r_frame_ok;
  logic                  r_crc_err;
  logic                  r_addr_miss;
  logic                  r_len_err;
  logic                  r_pre_err;
  logic [CNT_W-1:0]      r_good_cnt;
  logic [CNT_W-1:0]      r_bad_cnt;

  logic       w_report;
  logic       w_report_pre;
  logic       w_crc_err;
  logic       w_addr_miss;
  logic       w_len_err;
  logic       w_frame_ok;
  logic [7:0] w_mac_byte;

  // One byte of the reflected CRC32, LSB first.
  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] x;
    x = c ^ {24'h0, d};
    for (int i = 0; i < 8; i++) begin
      x = x[0] ? ((x >> 1) ^ CRC_POLY_R) : (x >> 1);
    end
    return x;
  endfunction

  // BOARD_MAC byte expected at DA position r_byte_cnt (MSB byte arrives first).
  always_comb begin
    w_mac_byte = 8'h00;
    case (r_byte_cnt[2:0])
      3'd0:    w_mac_byte = BOARD_MAC[47:40];
      3'd1:    w_mac_byte = BOARD_MAC[39:32];
      3'd2:    w_mac_byte = BOARD_MAC[31:24];
      3'd3:    w_mac_byte = BOARD_MAC[23:16];
      3'd4:    w_mac_byte = BOARD_MAC[15:8];
      3'd5:    w_mac_byte = BOARD_MAC[7:0];
      default: w_mac_byte = 8'h00;
    endcase
  end

  // A report fires on the first dv=0 cycle of any state that owns a frame.
  always_comb begin
    w_report     = 1'b0;
    w_report_pre = 1'b0;
    case (r_state)
      S_PRE, S_DROP: begin
        w_report     = ~rx.gmii_rx_dv;
        w_report_pre = ~rx.gmii_rx_dv;
      end
      S_DATA:  w_report = ~rx.gmii_rx_dv;
      default: ;
    endcase
    w_crc_err   = ~w_report_pre & (r_crc != CRC_RESID);
    w_addr_miss = ~w_report_pre & ((r_byte_cnt < 11'd6) | ~(r_da_bcast | r_da_board));
    w_len_err   = ~w_report_pre & ((r_byte_cnt < BYTE_CNT_W'(MIN_LEN)) |
                                   (r_byte_cnt > BYTE_CNT_W'(MAX_LEN)));
    w_frame_ok  = ~(w_crc_err | w_addr_miss | w_len_err | w_report_pre);
  end

  always_ff @(posedge gmii_rx_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_WAIT_IDLE;
      r_pre_cnt    <= '0;
      r_byte_cnt   <= '0;
      r_crc        <= '0;
      r_da_bcast   <= 1'b0;
      r_da_board   <= 1'b0;
      r_out_dv     <= 1'b0;
      r_out_data   <= '0;
      r_out_sof    <= 1'b0;
      r_frame_done <= 1'b0;
      r_frame_ok   <= 1'b0;
      r_crc_err    <= 1'b0;
      r_addr_miss  <= 1'b0;
      r_len_err    <= 1'b0;
      r_pre_err    <= 1'b0;
      r_good_cnt   <= '0;
      r_bad_cnt    <= '0;
    end else begin
      r_out_dv     <= 1'b0;
      r_out_sof    <= 1'b0;
      r_frame_done <= w_report;

      if (w_report) begin
        r_frame_ok  <= w_frame_ok;
        r_crc_err   <= w_crc_err;
        r_addr_miss <= w_addr_miss;
        r_len_err   <= w_len_err;
        r_pre_err   <= w_report_pre;
        if (w_frame_ok) begin
          if (r_good_cnt != '1) r_good_cnt <= r_good_cnt + 1'b1;
        end else begin
          if (r_bad_cnt != '1) r_bad_cnt <= r_bad_cnt + 1'b1;
        end
      end

      case (r_state)
        S_WAIT_IDLE: begin
          if (!rx.gmii_rx_dv) r_state <= S_IDLE;
        end
        S_IDLE: begin
          if (rx.gmii_rx_dv) begin
            if (rx.gmii_rxd == 8'h55) begin
              r_state   <= S_PRE;
              r_pre_cnt <= PRE_CNT_W'(1);
            end else begin
              r_state <= S_DROP;
            end
          end
        end
        S_PRE: begin
          if (!rx.gmii_rx_dv) begin
            r_state <= S_IDLE;
          end else if (rx.gmii_rxd == 8'h55) begin
            // An eighth preamble byte is too long.
            if (r_pre_cnt == PRE_CNT_W'(7)) r_state <= S_DROP;
            else                             r_pre_cnt <= r_pre_cnt + 1'b1;
          end else if (rx.gmii_rxd == 8'hD5) begin
            r_state    <= S_DATA;
            r_byte_cnt <= '0;
            r_crc      <= CRC_INIT;
            r_da_bcast <= 1'b1;
            r_da_board <= 1'b1;
          end else begin
            r_state <= S_DROP;
          end
        end
        S_DATA: begin
          if (!rx.gmii_rx_dv) begin
            r_state <= S_IDLE;
          end else begin
            r_out_dv   <= 1'b1;
            r_out_data <= rx.gmii_rxd;
            r_out_sof  <= (r_byte_cnt == '0);
            r_crc      <= crc_byte(r_crc, rx.gmii_rxd);
            if (r_byte_cnt != '1) r_byte_cnt <= r_byte_cnt + 1'b1;
            if (r_byte_cnt < 11'd6) begin
              if (rx.gmii_rxd != 8'hFF)       r_da_bcast <= 1'b0;
              if (rx.gmii_rxd != w_mac_byte)  r_da_board <= 1'b0;
            end
          end
        end
        S_DROP: begin
          if (!rx.gmii_rx_dv) r_state <= S_IDLE;
        end
        default: r_state <= S_WAIT_IDLE;
      endcase
    end
  end

  assign rx.out_dv     = r_out_dv;
  assign rx.out_data   = r_out_data;
  assign rx.out_sof    = r_out_sof;
  assign rx.frame_done = r_frame_done;
  assign rx.frame_ok   = r_frame_ok;
  assign rx.crc_err    = r_crc_err;
  assign rx.addr_miss  = r_addr_miss;
  assign rx.len_err    = r_len_err;
  assign rx.pre_err    = r_pre_err;
  assign rx.good_cnt   = r_good_cnt;
  assign rx.bad_cnt    = r_bad_cnt;

endmodule

// File: tb/tb_gmii_rx_checker.sv
// Directed bench for gmii_rx_checker: builds Ethernet frames with a locally computed FCS,
// drives them on negedges and checks forwarding and per-frame status.
module tb_gmii_rx_checker;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #4 clk = ~clk;

  gmii_rx_checker_if #(.CNT_W(16)) u_if ();

  gmii_rx_checker u_dut (
    .gmii_rx_clk (clk),
    .rst_n       (rst_n),
    .rx          (u_if)
  );

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] frm [0:2047];
  int         frm_len = 0;

  int         mon_dv    = 0;
  int         mon_sof   = 0;
  int         mon_done  = 0;
  int         mon_bad   = 0;
  int         mon_idx   = 0;
  logic [7:0] mon_first = 8'h00;
  logic       mon_ok    = 1'b0;
  logic       mon_crc   = 1'b0;
  logic       mon_addr  = 1'b0;
  logic       mon_len   = 1'b0;
  logic       mon_pre   = 1'b0;
  logic       prev_dv   = 1'b0;

  int b_dv, b_sof, b_done, b_bad;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Standard Ethernet FCS, bit-serial formulation.
  function automatic logic [31:0] eth_crc_step(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] x;
    logic        fb;
    x = c;
    for (int b = 0; b < 8; b++) begin
      fb = x[0] ^ d[b];
      x  = x >> 1;
      if (fb) x = x ^ 32'hEDB8_8320;
    end
    return x;
  endfunction

  task automatic build(input logic [47:0] da, input int len);
    logic [31:0] c;
    for (int i = 0; i < 6; i++) frm[i] = da[8*(5-i) +: 8];
    frm[6] = 8'h02; frm[7] = 8'h00; frm[8] = 8'h00;
    frm[9] = 8'h00; frm[10] = 8'h00; frm[11] = 8'h01;
    frm[12] = 8'h08; frm[13] = 8'h06;
    for (int i = 14; i < len - 4; i++) frm[i] = 8'(i * 7 + 3);
    c = 32'hFFFF_FFFF;
    for (int i = 0; i < len - 4; i++) c = eth_crc_step(c, frm[i]);
    c = ~c;
    for (int k = 0; k < 4; k++) frm[len-4+k] = c[8*k +: 8];
    frm_len = len;
  endtask

  task automatic drive(input logic dv, input logic [7:0] d);
    @(negedge clk);
    u_if.gmii_rx_dv = dv;
    u_if.gmii_rxd   = d;
  endtask

  task automatic send(input int npre, input logic [7:0] sfd, input int gap);
    for (int i = 0; i < npre; i++) drive(1'b1, 8'h55);
    drive(1'b1, sfd);
    for (int i = 0; i < frm_len; i++) drive(1'b1, frm[i]);
    for (int i = 0; i < gap; i++) drive(1'b0, 8'h00);
  endtask

  task automatic snap();
    b_dv   = mon_dv;
    b_sof  = mon_sof;
    b_done = mon_done;
    b_bad  = mon_bad;
  endtask

  // Output monitor: forwarded bytes against the frame buffer, status latched at frame_done.
  always @(negedge clk) begin
    if (u_if.out_dv) begin
      mon_dv++;
      if (u_if.out_sof) begin
        mon_sof++;
        mon_first = u_if.out_data;
        mon_idx   = 0;
      end
      if (u_if.out_data !== frm[mon_idx]) mon_bad++;
      if (mon_idx < 2047) mon_idx++;
    end
    if (u_if.frame_done) begin
      mon_done++;
      mon_ok   = u_if.frame_ok;
      mon_crc  = u_if.crc_err;
      mon_addr = u_if.addr_miss;
      mon_len  = u_if.len_err;
      mon_pre  = u_if.pre_err;
      if (u_if.out_dv || (!u_if.pre_err && !prev_dv)) mon_bad++;
    end
    prev_dv = u_if.out_dv;
  end

  initial begin
    int rel_dv;
    u_if.gmii_rx_dv = 1'b0;
    u_if.gmii_rxd   = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_out_dv",     32'(u_if.out_dv),     0);
    chk("rst_frame_done", 32'(u_if.frame_done), 0);
    chk("rst_frame_ok",   32'(u_if.frame_ok),   0);
    chk("rst_good_cnt",   32'(u_if.good_cnt),   0);
    chk("rst_bad_cnt",    32'(u_if.bad_cnt),    0);
    rst_n = 1'b1;
    repeat (3) drive(1'b0, 8'h00);

    // Broadcast 64B frame
    build(48'hFFFF_FFFF_FFFF, 64);
    snap();
    send(7, 8'hD5, 6);
    chk("t1_dv_cycles", 32'(mon_dv - b_dv),     64);
    chk("t1_sof",       32'(mon_sof - b_sof),   1);
    chk("t1_first",     32'(mon_first),         32'hFF);
    chk("t1_done",      32'(mon_done - b_done), 1);
    chk("t1_ok",        32'(mon_ok),            1);
    chk("t1_good",      32'(u_if.good_cnt),     1);
    chk("t1_data",      32'(mon_bad - b_bad),   0);

    // Corrupted payload byte 20
    build(48'hFFFF_FFFF_FFFF, 64);
    frm[20] = frm[20] ^ 8'h01;
    snap();
    send(7, 8'hD5, 6);
    chk("t2_crc_err", 32'(mon_crc),         1);
    chk("t2_ok",      32'(mon_ok),          0);
    chk("t2_addr",    32'(mon_addr),        0);
    chk("t2_bad_cnt", 32'(u_if.bad_cnt),    1);
    chk("t2_data",    32'(mon_bad - b_bad), 0);

    // Unicast to a neighbouring MAC, then to the board MAC
    build(48'h00_11_22_33_44_56, 64);
    send(7, 8'hD5, 6);
    chk("t3_addr", 32'(mon_addr),      1);
    chk("t3_crc",  32'(mon_crc),       0);
    chk("t3_len",  32'(mon_len),       0);
    chk("t3_bad",  32'(u_if.bad_cnt),  2);
    build(48'h00_11_22_33_44_55, 64);
    send(7, 8'hD5, 6);
    chk("t3b_ok",   32'(mon_ok),        1);
    chk("t3b_good", 32'(u_if.good_cnt), 2);

    // Length boundaries
    build(48'hFFFF_FFFF_FFFF, 60);
    send(7, 8'hD5, 6);
    chk("t4_60_len", 32'(mon_len), 1);
    chk("t4_60_crc", 32'(mon_crc), 0);
    build(48'hFFFF_FFFF_FFFF, 1519);
    send(7, 8'hD5, 6);
    chk("t4_1519_len", 32'(mon_len),     1);
    chk("t4_1519_bad", 32'(u_if.bad_cnt), 4);
    build(48'hFFFF_FFFF_FFFF, 1518);
    snap();
    send(7, 8'hD5, 6);
    chk("t4_1518_ok",   32'(mon_ok),          1);
    chk("t4_1518_dv",   32'(mon_dv - b_dv),   1518);
    chk("t4_1518_good", 32'(u_if.good_cnt),   3);
    chk("t4_1518_data", 32'(mon_bad - b_bad), 0);

    // Preamble errors
    build(48'hFFFF_FFFF_FFFF, 64);
    snap();
    send(7, 8'h5D, 6);
    chk("t5_bad_sfd_pre",  32'(mon_pre),         1);
    chk("t5_bad_sfd_dv",   32'(mon_dv - b_dv),   0);
    chk("t5_bad_sfd_crc",  32'(mon_crc),         0);
    chk("t5_bad_sfd_done", 32'(mon_done - b_done), 1);
    chk("t5_bad_sfd_cnt",  32'(u_if.bad_cnt),    5);
    snap();
    send(9, 8'hD5, 6);
    chk("t5_long_pre",     32'(mon_pre),         1);
    chk("t5_long_dv",      32'(mon_dv - b_dv),   0);
    chk("t5_long_cnt",     32'(u_if.bad_cnt),    6);

    // Back-to-back with a single idle cycle
    build(48'hFFFF_FFFF_FFFF, 64);
    snap();
    send(7, 8'hD5, 1);
    send(7, 8'hD5, 6);
    chk("t6_done", 32'(mon_done - b_done), 2);
    chk("t6_sof",  32'(mon_sof - b_sof),   2);
    chk("t6_dv",   32'(mon_dv - b_dv),     128);
    chk("t6_good", 32'(u_if.good_cnt),     5);
    chk("t6_data", 32'(mon_bad - b_bad),   0);

    // Reset asserted at byte 30, released while dv is still high
    snap();
    rel_dv = 0;
    for (int i = 0; i < 7; i++) drive(1'b1, 8'h55);
    drive(1'b1, 8'hD5);
    for (int i = 0; i < frm_len; i++) begin
      drive(1'b1, frm[i]);
      if (i == 30) begin
        rst_n = 1'b0;
        #1;
        chk("t6r_out_dv", 32'(u_if.out_dv),   0);
        chk("t6r_good",   32'(u_if.good_cnt), 0);
        chk("t6r_bad",    32'(u_if.bad_cnt),  0);
      end
      if (i == 32) begin
        rst_n  = 1'b1;
        rel_dv = mon_dv;
      end
    end
    repeat (6) drive(1'b0, 8'h00);
    chk("t6r_done",     32'(mon_done - b_done), 0);
    chk("t6r_dv_after", 32'(mon_dv - rel_dv),   0);
    chk("t6r_good_end", 32'(u_if.good_cnt),     0);
    chk("t6r_bad_end",  32'(u_if.bad_cnt),      0);

    // Recovery frame
    snap();
    send(7, 8'hD5, 6);
    chk("t6r_rec_done", 32'(mon_done - b_done), 1);
    chk("t6r_rec_good", 32'(u_if.good_cnt),     1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
